// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Request/response bundle shared by the fetch port, the load/store port and
// the external memory bus around mem_port_arbiter.
//
// Signals (requester -> responder unless noted):
//   req     request pending, held until gnt
//   we      1 = write
//   addr    byte address, ADDR_W bits
//   be      byte enables, 4 bits
//   wdata   write data, DATA_W bits
//   gnt     (responder -> requester) request accepted, 1-cycle pulse
//   rvalid  (responder -> requester) response valid, 1-cycle pulse
//   rdata   (responder -> requester) read data, DATA_W bits
//
// Modports:
//   master / slave              full read/write port
//   fetch_master / fetch_slave  read-only subset used by instruction fetch
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [3:0]        be;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, we, addr, be, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, be, wdata,
      output gnt, rvalid, rdata
   );

   modport fetch_master (
      output req, addr,
      input  gnt, rvalid, rdata
   );

   modport fetch_slave (
      input  req, addr,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares the core's single memory port between instruction fetch and the
// load/store unit. One transaction is in flight at a time. Load/store
// requests win, except that after MAX_DATA_STREAK consecutive data grants
// with fetch waiting, fetch is served once.
//
// Ports:
//   clk     core clock
//   rst_n   asynchronous active-low reset
//   fetch   fetch_slave  : req/addr in, gnt/rvalid/rdata out
//   lsu     slave        : req/we/addr/be/wdata in, gnt/rvalid/rdata out
//   mem     master       : req/we/addr/be/wdata out, gnt/rvalid/rdata in
//
// Parameters:
//   ADDR_W           address width
//   REG_LEN          data width (the core's register length, 32)
//   MAX_DATA_STREAK  data grants allowed while fetch waits, 1..15
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W          = 32,
   parameter int REG_LEN         = 32,
   parameter int MAX_DATA_STREAK = 4
) (
   input logic                     clk,
   input logic                     rst_n,
   mem_port_arbiter_if.fetch_slave fetch,
   mem_port_arbiter_if.slave       lsu,
   mem_port_arbiter_if.master      mem
);

   typedef enum logic {IDLE, WAIT_RSP} state_t;
   typedef enum logic {OWN_IF, OWN_LS} owner_t;

   localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

   state_t     state, state_next;
   owner_t     owner, owner_next;
   logic [3:0] streak, streak_next;

   logic any_req;
   logic sel_if;
   logic accept;

   // Fetch is chosen when it is alone, or when the data streak has used up
   // its allowance; otherwise load/store has priority.
   assign any_req = fetch.req | lsu.req;
   assign sel_if  = fetch.req & (~lsu.req | (streak == STREAK_MAX));
   assign accept  = (state == IDLE) & any_req & mem.gnt;

   // State register: FSM state, the owner of the outstanding transaction and
   // the consecutive-data-grant counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         owner  <= OWN_IF;
         streak <= 4'd0;
      end else begin
         state  <= state_next;
         owner  <= owner_next;
         streak <= streak_next;
      end
   end

   // Next-state logic. A grant in IDLE moves to WAIT_RSP and records who owns
   // the response; the single response returns us to IDLE. The streak only
   // counts data grants that happened while fetch was actually waiting, and
   // collapses to zero whenever fetch is not requesting or is served.
   always_comb begin
      state_next  = state;
      owner_next  = owner;
      streak_next = streak;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = WAIT_RSP;
               owner_next = sel_if ? OWN_IF : OWN_LS;
            end
         end
         WAIT_RSP: begin
            if (mem.rvalid) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (!fetch.req) begin
         streak_next = 4'd0;
      end else if (accept) begin
         if (sel_if) begin
            streak_next = 4'd0;
         end else if (streak != STREAK_MAX) begin
            streak_next = streak + 4'd1;
         end
      end
   end

   // Output logic. In IDLE the selected master's fields go straight onto the
   // bus and its gnt mirrors mem.gnt; fetch always reads full words. In
   // WAIT_RSP the bus is quiet and mem.rvalid/rdata are steered to the owner.
   // rst_n gates the bus request so nothing is issued while reset is held.
   always_comb begin
      mem.req      = 1'b0;
      mem.we       = 1'b0;
      mem.addr     = '0;
      mem.be       = 4'b0000;
      mem.wdata    = '0;
      fetch.gnt    = 1'b0;
      fetch.rvalid = 1'b0;
      fetch.rdata  = '0;
      lsu.gnt      = 1'b0;
      lsu.rvalid   = 1'b0;
      lsu.rdata    = '0;
      case (state)
         IDLE: begin
            if (rst_n && any_req) begin
               mem.req = 1'b1;
               if (sel_if) begin
                  mem.addr  = fetch.addr;
                  mem.be    = 4'b1111;
                  fetch.gnt = mem.gnt;
               end else begin
                  mem.we    = lsu.we;
                  mem.addr  = lsu.addr;
                  mem.be    = lsu.be;
                  mem.wdata = lsu.wdata;
                  lsu.gnt   = mem.gnt;
               end
            end
         end
         WAIT_RSP: begin
            if (mem.rvalid) begin
               if (owner == OWN_IF) begin
                  fetch.rvalid = 1'b1;
                  fetch.rdata  = mem.rdata;
               end else begin
                  lsu.rvalid = 1'b1;
                  lsu.rdata  = mem.rdata;
               end
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed testbench for mem_port_arbiter with MAX_DATA_STREAK = 4. Inputs
// change 1 time unit after the rising edge and outputs are sampled 1 time
// unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) fetch_bus ();
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ls_bus ();
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

   mem_port_arbiter #(
      .ADDR_W(32),
      .REG_LEN(32),
      .MAX_DATA_STREAK(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .fetch(fetch_bus),
      .lsu(ls_bus),
      .mem(mem_bus)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Return every stimulus input to its quiet value.
   task automatic idle_inputs();
      fetch_bus.req   = 1'b0;
      fetch_bus.addr  = '0;
      fetch_bus.we    = 1'b0;
      fetch_bus.be    = 4'b0000;
      fetch_bus.wdata = '0;
      ls_bus.req      = 1'b0;
      ls_bus.we       = 1'b0;
      ls_bus.addr     = '0;
      ls_bus.be       = 4'b1111;
      ls_bus.wdata    = '0;
      mem_bus.gnt     = 1'b0;
      mem_bus.rvalid  = 1'b0;
      mem_bus.rdata   = '0;
   endtask

   // Reset held with both masters requesting: nothing may reach the bus.
   // After release, load/store must be the first request presented.
   task automatic test_reset();
      idle_inputs();
      rst_n          = 1'b0;
      fetch_bus.req  = 1'b1;
      fetch_bus.addr = 32'h0000_0040;
      ls_bus.req     = 1'b1;
      ls_bus.addr    = 32'h0000_0200;
      mem_bus.gnt    = 1'b1;
      tick();
      #1;
      checks++;
      if (mem_bus.req !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_bus.req);
      end
      checks++;
      if ({fetch_bus.gnt, ls_bus.gnt, fetch_bus.rvalid, ls_bus.rvalid} !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL reset_gnt_rvalid: got %b expected 0000",
                  {fetch_bus.gnt, ls_bus.gnt, fetch_bus.rvalid, ls_bus.rvalid});
      end
      mem_bus.gnt = 1'b0;
      rst_n       = 1'b1;
      #1;
      checks++;
      if (mem_bus.req !== 1'b1 || mem_bus.addr !== 32'h0000_0200) begin
         errors++;
         $display("[TB] FAIL reset_release_ls_first: got req=%b addr=%h expected req=1 addr=00000200",
                  mem_bus.req, mem_bus.addr);
      end
      tick();
      idle_inputs();
      tick();
   endtask

   // A response while IDLE must not produce any master rvalid.
   task automatic test_idle_rvalid();
      mem_bus.rvalid = 1'b1;
      mem_bus.rdata  = 32'h1111_2222;
      #1;
      checks++;
      if (fetch_bus.rvalid !== 1'b0 || ls_bus.rvalid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL idle_rvalid_ignored: got if=%b ls=%b expected 0 0",
                  fetch_bus.rvalid, ls_bus.rvalid);
      end
      tick();
      idle_inputs();
   endtask

   // Single load granted in cycle 0, answered in cycle 2.
   task automatic test_single_load();
      ls_bus.req  = 1'b1;
      ls_bus.addr = 32'h0000_0100;
      mem_bus.gnt = 1'b1;
      #1;
      checks++;
      if (mem_bus.req !== 1'b1 || mem_bus.addr !== 32'h0000_0100 || mem_bus.we !== 1'b0 ||
          mem_bus.be !== 4'b1111) begin
         errors++;
         $display("[TB] FAIL load_bus_fields: got req=%b addr=%h we=%b be=%b expected 1 00000100 0 1111",
                  mem_bus.req, mem_bus.addr, mem_bus.we, mem_bus.be);
      end
      checks++;
      if (ls_bus.gnt !== 1'b1 || fetch_bus.gnt !== 1'b0) begin
         errors++;
         $display("[TB] FAIL load_gnt: got ls=%b if=%b expected 1 0", ls_bus.gnt, fetch_bus.gnt);
      end
      tick();
      idle_inputs();
      #1;
      checks++;
      if (mem_bus.req !== 1'b0 || ls_bus.rvalid !== 1'b0 || fetch_bus.rvalid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL load_wait_quiet: got req=%b ls_rv=%b if_rv=%b expected 0 0 0",
                  mem_bus.req, ls_bus.rvalid, fetch_bus.rvalid);
      end
      tick();
      mem_bus.rvalid = 1'b1;
      mem_bus.rdata  = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (ls_bus.rvalid !== 1'b1 || ls_bus.rdata !== 32'hDEAD_BEEF) begin
         errors++;
         $display("[TB] FAIL load_rdata: got rvalid=%b rdata=%h expected 1 deadbeef",
                  ls_bus.rvalid, ls_bus.rdata);
      end
      checks++;
      if (fetch_bus.rvalid !== 1'b0 || fetch_bus.rdata !== 32'h0) begin
         errors++;
         $display("[TB] FAIL load_if_quiet: got rvalid=%b rdata=%h expected 0 00000000",
                  fetch_bus.rvalid, fetch_bus.rdata);
      end
      tick();
      idle_inputs();
   endtask

   // Store fields pass through unchanged; completion arrives on ls rvalid.
   task automatic test_store();
      ls_bus.req   = 1'b1;
      ls_bus.we    = 1'b1;
      ls_bus.addr  = 32'h0000_0300;
      ls_bus.be    = 4'b0100;
      ls_bus.wdata = 32'h00AB_0000;
      mem_bus.gnt  = 1'b1;
      #1;
      checks++;
      if (mem_bus.we !== 1'b1 || mem_bus.be !== 4'b0100 || mem_bus.wdata !== 32'h00AB_0000 ||
          ls_bus.gnt !== 1'b1) begin
         errors++;
         $display("[TB] FAIL store_fields: got we=%b be=%b wdata=%h gnt=%b expected 1 0100 00ab0000 1",
                  mem_bus.we, mem_bus.be, mem_bus.wdata, ls_bus.gnt);
      end
      tick();
      idle_inputs();
      mem_bus.rvalid = 1'b1;
      mem_bus.rdata  = 32'h1234_5678;
      #1;
      checks++;
      if (ls_bus.rvalid !== 1'b1 || fetch_bus.rvalid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL store_ack: got ls_rv=%b if_rv=%b expected 1 0",
                  ls_bus.rvalid, fetch_bus.rvalid);
      end
      tick();
      idle_inputs();
   endtask

   // Both masters always requesting, bus always granting, one-cycle response.
   // With a streak limit of 4 the grant order is LS x4, IF, LS x4, IF.
   task automatic test_starvation();
      logic [9:0] expect_if;
      expect_if      = 10'b10000_10000;
      fetch_bus.req  = 1'b1;
      fetch_bus.addr = 32'h0000_1000;
      ls_bus.req     = 1'b1;
      ls_bus.addr    = 32'h0000_2000;
      mem_bus.gnt    = 1'b1;
      for (int i = 0; i < 10; i++) begin
         mem_bus.rvalid = 1'b0;
         #1;
         checks++;
         if (fetch_bus.gnt !== expect_if[i] || ls_bus.gnt !== ~expect_if[i]) begin
            errors++;
            $display("[TB] FAIL starve_grant_%0d: got if_gnt=%b ls_gnt=%b expected %b %b",
                     i, fetch_bus.gnt, ls_bus.gnt, expect_if[i], ~expect_if[i]);
         end
         tick();
         mem_bus.rvalid = 1'b1;
         mem_bus.rdata  = 32'hA000_0000 + 32'(i);
         #1;
         checks++;
         if (mem_bus.req !== 1'b0 || fetch_bus.gnt !== 1'b0 || ls_bus.gnt !== 1'b0 ||
             fetch_bus.rvalid !== expect_if[i] || ls_bus.rvalid !== ~expect_if[i]) begin
            errors++;
            $display("[TB] FAIL starve_rsp_%0d: got req=%b gnt=%b%b if_rv=%b ls_rv=%b expected 0 00 %b %b",
                     i, mem_bus.req, fetch_bus.gnt, ls_bus.gnt, fetch_bus.rvalid, ls_bus.rvalid,
                     expect_if[i], ~expect_if[i]);
         end
         tick();
      end
      idle_inputs();
      tick();
   endtask

   // Bus holds off for 3 cycles: request and fields stay put, no grant leaks.
   task automatic test_bus_stall();
      ls_bus.req   = 1'b1;
      ls_bus.we    = 1'b1;
      ls_bus.addr  = 32'h0000_0400;
      ls_bus.be    = 4'b0011;
      ls_bus.wdata = 32'h0000_CAFE;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (mem_bus.req !== 1'b1 || mem_bus.addr !== 32'h0000_0400 || mem_bus.be !== 4'b0011 ||
             mem_bus.wdata !== 32'h0000_CAFE || ls_bus.gnt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_cycle_%0d: got req=%b addr=%h be=%b wdata=%h gnt=%b expected 1 00000400 0011 0000cafe 0",
                     c, mem_bus.req, mem_bus.addr, mem_bus.be, mem_bus.wdata, ls_bus.gnt);
         end
         tick();
      end
      mem_bus.gnt = 1'b1;
      #1;
      checks++;
      if (ls_bus.gnt !== 1'b1) begin
         errors++;
         $display("[TB] FAIL stall_grant: got %b expected 1", ls_bus.gnt);
      end
      tick();
      idle_inputs();
      mem_bus.rvalid = 1'b1;
      #1;
      checks++;
      if (ls_bus.rvalid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL stall_ack: got %b expected 1", ls_bus.rvalid);
      end
      tick();
      idle_inputs();
   endtask

   // Reset lands while a fetch is outstanding: the late response is dropped
   // and the next data request is served normally.
   task automatic test_reset_midflight();
      fetch_bus.req  = 1'b1;
      fetch_bus.addr = 32'h0000_0500;
      mem_bus.gnt    = 1'b1;
      #1;
      checks++;
      if (fetch_bus.gnt !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midflight_if_gnt: got %b expected 1", fetch_bus.gnt);
      end
      tick();
      idle_inputs();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      mem_bus.rvalid = 1'b1;
      mem_bus.rdata  = 32'h0000_0055;
      #1;
      checks++;
      if (fetch_bus.rvalid !== 1'b0 || ls_bus.rvalid !== 1'b0 || mem_bus.req !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midflight_dropped: got if_rv=%b ls_rv=%b req=%b expected 0 0 0",
                  fetch_bus.rvalid, ls_bus.rvalid, mem_bus.req);
      end
      tick();
      idle_inputs();
      ls_bus.req  = 1'b1;
      ls_bus.addr = 32'h0000_0600;
      mem_bus.gnt = 1'b1;
      #1;
      checks++;
      if (ls_bus.gnt !== 1'b1 || mem_bus.addr !== 32'h0000_0600) begin
         errors++;
         $display("[TB] FAIL midflight_next_gnt: got gnt=%b addr=%h expected 1 00000600",
                  ls_bus.gnt, mem_bus.addr);
      end
      tick();
      idle_inputs();
      mem_bus.rvalid = 1'b1;
      mem_bus.rdata  = 32'h0BAD_F00D;
      #1;
      checks++;
      if (ls_bus.rvalid !== 1'b1 || ls_bus.rdata !== 32'h0BAD_F00D) begin
         errors++;
         $display("[TB] FAIL midflight_next_rsp: got rvalid=%b rdata=%h expected 1 0badf00d",
                  ls_bus.rvalid, ls_bus.rdata);
      end
      tick();
      idle_inputs();
   endtask

   // Run every scenario in order, then report.
   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      idle_inputs();
      test_reset();
      test_idle_rvalid();
      test_single_load();
      test_store();
      test_starvation();
      test_bus_stall();
      test_reset_midflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the core's single memory port between instruction fetch (IF) and the load/store unit (LS). It sits between the fetch stage, the store-lane formatter that produces byte enables and lane-aligned write data, and the external memory bus. One transaction is in flight at a time. Data requests have priority, and a streak counter guarantees fetch forward progress.

## Interface
Parameters:
- ADDR_W, 32, address width
- REG_LEN, from rysyPkg (32), data width
- MAX_DATA_STREAK, 4, consecutive LS grants allowed while IF waits; legal range 1..15

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; held stable until if_gnt
- if_addr  in  ADDR_W  fetch address (word aligned)
- if_gnt  out  1  fetch request accepted by bus (1-cycle pulse)
- if_rvalid  out  1  fetch read data valid (1-cycle pulse)
- if_rdata  out  REG_LEN  fetch read data
- ls_req  in  1  load/store request; held stable until ls_gnt
- ls_we  in  1  1 = store
- ls_addr  in  ADDR_W  data address
- ls_be  in  4  byte enables from the store-lane formatter; 4'b1111 for loads
- ls_wdata  in  REG_LEN  lane-aligned store data
- ls_gnt  out  1  LS request accepted (1-cycle pulse)
- ls_rvalid  out  1  LS completion; load data valid, or store acknowledged
- ls_rdata  out  REG_LEN  load data
- mem_req, mem_we  out  1  bus request and write strobe
- mem_addr  out  ADDR_W; mem_be  out  4; mem_wdata  out  REG_LEN
- mem_gnt  in  1  bus accepts the current request
- mem_rvalid  in  1  bus response; exactly one per accepted request
- mem_rdata  in  REG_LEN  bus read data

## Operation
- FSM states: IDLE and WAIT_RSP. Registered state: `owner` (IF or LS) and `streak` (4 bits).
- IDLE:
  - If any request is pending, drive mem_req=1 combinationally, with the fields of the selected master.
  - Selection: LS wins, unless if_req=1 and streak==MAX_DATA_STREAK, in which case IF wins.
  - IF-selected request: mem_we=0, mem_be=4'b1111, mem_wdata=0.
  - When mem_gnt=1: pulse the selected master's gnt in the same cycle, latch owner, go to WAIT_RSP.
  - If mem_gnt=0: stay in IDLE and re-arbitrate next cycle. Selection may change, because requests are held.
- WAIT_RSP:
  - mem_req=0 and all mem_* outputs are 0.
  - When mem_rvalid=1: pulse the owner's rvalid. Route mem_rdata to the owner's rdata. Go to IDLE.
- Streak counter:
  - LS grant while if_req=1: streak increments, saturating at MAX_DATA_STREAK.
  - IF grant, or any cycle with if_req=0: streak resets to 0.
  - LS grant with if_req=0: streak stays 0.
- rdata outputs:
  - Combinational copies of mem_rdata, gated to zero when the corresponding rvalid is 0.
  - if_rvalid and ls_rvalid are never both 1.
- Requests that arrive in WAIT_RSP are not visible on the bus. They are arbitrated in the next IDLE cycle.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=IDLE, owner=IF, streak=0.
  - All gnt/rvalid outputs are 0. mem_req=0 while in reset.
- Latency, minimum 2 cycles per transaction:
  - Cycle 0: request, mem_gnt, master gnt.
  - Cycle ≥1: mem_rvalid, master rvalid.
- Back-to-back: rvalid in cycle N means the earliest next mem_req is cycle N+1. This gives a throughput of 1 transaction per 2 cycles.
- mem_rvalid in IDLE is ignored; no master rvalid is produced.
- mem_gnt in WAIT_RSP is ignored.
- Reset asserted mid-transaction:
  - The outstanding response is dropped and no rvalid is delivered.
  - A post-reset mem_rvalid arrives in IDLE and is ignored.
- The gnt path from mem_gnt is combinational. The rvalid path from mem_rvalid is combinational. No registered outputs besides the FSM state.

## Test plan
- Reset: hold rst_n=0 with if_req=ls_req=1 -> mem_req=0, all gnt/rvalid 0. Release rst_n -> LS is issued first.
- Single load: ls_req, ls_addr=0x100, mem_gnt=1 in cycle 0, mem_rvalid=1 with rdata=0xDEADBEEF in cycle 2 -> ls_gnt in cycle 0, ls_rvalid and ls_rdata=0xDEADBEEF in cycle 2, if_rvalid=0 throughout.
- Store pass-through: ls_we=1, ls_be=4'b0100, ls_wdata=0x00AB0000 -> mem_we=1, mem_be=4'b0100, mem_wdata=0x00AB0000. Completion is signalled on ls_rvalid.
- Starvation guard (MAX_DATA_STREAK=4): if_req and ls_req held high, mem_gnt always 1, mem_rvalid 1 cycle after each grant -> grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF.
- Bus stall: mem_gnt=0 for 3 cycles with ls_req=1 -> mem_req stays 1 with stable fields, and no ls_gnt. Grant arrives in cycle 3 -> ls_gnt in cycle 3.
- Reset mid-flight: IF granted, rst_n pulsed low before mem_rvalid, then mem_rvalid arrives -> no if_rvalid, state IDLE, next ls_req served normally.
